universal_shift_reg: RTL
========================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits, legal range 2..64.
REQ-002 Parameter RESET_VAL, default 0: value loaded into q by clear; WIDTH bits wide.
REQ-003 Clocking and reset: one clock, clk; reset clear is asynchronous and active-high.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port clear, input, 1 bit: asynchronous active-high reset.
REQ-006 Port en, input, 1 bit: operation enable; when 0, all state holds.
REQ-007 Port mode, input, 3 bits: operation select (REQ-013).
REQ-008 Port d, input, WIDTH bits: parallel load data.
REQ-009 Port sin_l and sin_r, input, 1 bit each: serial inputs for shift-left (into bit 0) and shift-right (into bit WIDTH-1).
REQ-010 Port q and qbar, output, WIDTH bits each: register value and its bitwise complement.
REQ-011 Port sout_l and sout_r, output, 1 bit each: q[WIDTH-1] and q[0].
REQ-012 Port cnt, output, $clog2(WIDTH+1) bits: shifts since last load; port done, output, 1 bit: cnt == WIDTH.

Function
REQ-013 Mode encoding: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 SCLR (synchronous load of RESET_VAL), 5 ROTL, 6 ROTR, 7 HOLD.
REQ-014 All updates occur on the rising clk edge with en=1; latency is one cycle from input to q.
REQ-015 LOAD: q <= d; cnt <= 0.
REQ-016 SHL: q <= {q[WIDTH-2:0], sin_l}; SHR: q <= {sin_r, q[WIDTH-1:1]}.
REQ-017 ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; ROTR: q <= {q[0], q[WIDTH-1:1]}.
REQ-018 Each SHL/SHR/ROTL/ROTR cycle increments cnt by 1; cnt saturates at WIDTH and never wraps.
REQ-019 SCLR: q <= RESET_VAL; cnt <= 0; done deasserts on the following cycle.
REQ-020 HOLD or en=0: q and cnt unchanged, irrespective of d, sin_l, and sin_r.
REQ-021 qbar SHALL equal ~q at all times, including during and immediately after clear.
REQ-022 sout_l, sout_r, and done are combinational from registered state only; there is no input-to-output combinational path.
REQ-023 LOAD while done=1 clears cnt and done on the next cycle; a shift in the same cycle cannot occur, because mode is exclusive.

Reset
REQ-024 clear=1 forces q=RESET_VAL, qbar=~RESET_VAL, cnt=0, and done=0 immediately, without waiting for clk.
REQ-025 clear overrides en and mode; an operation in progress is discarded.
REQ-026 On the first clk edge after clear deasserts, normal operation resumes with no dead cycle.

Configuration
REQ-027 Macro UNIVERSAL_SHIFT_REG_ROTATE_EN, when defined: modes 5 and 6 rotate as in REQ-017 and count as shifts.
REQ-028 Without UNIVERSAL_SHIFT_REG_ROTATE_EN, modes 5 and 6 behave as HOLD: q and cnt are unchanged, and no rotate logic is synthesised.

Structure
REQ-029 Shared package usr_pkg SHALL hold the mode_t 3-bit enumeration (HOLD, LOAD, SHL, SHR, SCLR, ROTL, ROTR) and the function computing the cnt width.
REQ-030 One sub-module, usr_shift_counter, SHALL implement the saturating cnt/done logic (inputs clk, clear, load, step); the data path stays in the top module.

Verification
REQ-031 Use WIDTH=8, RESET_VAL=8'hA5. Assert clear mid-cycle -> q=8'hA5, qbar=8'h5A, and cnt=0 before the next clk edge.
REQ-032 LOAD d=8'h81, then SHL with sin_l=0 for 1 cycle -> q=8'h02, sout_l=0, cnt=1.
REQ-033 LOAD 8'h01, then 8 SHR cycles with sin_r=1 -> q=8'hFF, cnt=8, done=1; a 9th SHR leaves cnt=8.
REQ-034 Rotate check:
- With ROTATE_EN: LOAD 8'h80, ROTL once -> q=8'h01, cnt=1.
- Without ROTATE_EN: the same stimulus -> q=8'h80, cnt=0.
REQ-035 en=0 with mode=LOAD and d=8'h3C for 4 cycles -> q and cnt unchanged; qbar == ~q checked every cycle.
REQ-036 SCLR after done=1 -> q=8'hA5 and cnt=0 next cycle; assert clear during a SHR burst -> immediate reset, and shifting resumes on the first edge after release.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for universal_shift_reg: operation modes and counter sizing.
package usr_pkg;

   typedef enum logic [2:0] {
      HOLD = 3'd0,
      LOAD = 3'd1,
      SHL  = 3'd2,
      SHR  = 3'd3,
      SCLR = 3'd4,
      ROTL = 3'd5,
      ROTR = 3'd6
   } mode_t;

   // Bits needed to represent 0..width shift counts.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Saturating shift counter: clears on load, steps once per shift, sticks at WIDTH.
module usr_shift_counter
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                            clk,
   input  logic                            clear,
   input  logic                            load,
   input  logic                            step,
   output logic [cnt_width(WIDTH)-1:0]     cnt,
   output logic                            done
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= '0;
      end else if (step && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt  = cnt_q;
   assign done = (cnt_q == CNT_MAX);

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with load, shifts, sync clear and saturating shift count.
// Rotate modes are built only when UNIVERSAL_SHIFT_REG_ROTATE_EN is defined.
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                        clk,
   input  logic                        clear,
   input  logic                        en,
   input  logic [2:0]                  mode,
   input  logic [WIDTH-1:0]            d,
   input  logic                        sin_l,
   input  logic                        sin_r,
   output logic [WIDTH-1:0]            q,
   output logic [WIDTH-1:0]            qbar,
   output logic                        sout_l,
   output logic                        sout_r,
   output logic [cnt_width(WIDTH)-1:0] cnt,
   output logic                        done
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             cnt_load;
   logic             cnt_step;

   always_comb begin
      q_d      = q_q;
      cnt_load = 1'b0;
      cnt_step = 1'b0;
      if (en) begin
         case (mode)
            LOAD: begin
               q_d      = d;
               cnt_load = 1'b1;
            end
            SHL: begin
               q_d      = {q_q[WIDTH-2:0], sin_l};
               cnt_step = 1'b1;
            end
            SHR: begin
               q_d      = {sin_r, q_q[WIDTH-1:1]};
               cnt_step = 1'b1;
            end
            SCLR: begin
               q_d      = RESET_VAL;
               cnt_load = 1'b1;
            end
`ifdef UNIVERSAL_SHIFT_REG_ROTATE_EN
            ROTL: begin
               q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
               cnt_step = 1'b1;
            end
            ROTR: begin
               q_d      = {q_q[0], q_q[WIDTH-1:1]};
               cnt_step = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         q_q <= RESET_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   usr_shift_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk   (clk),
      .clear (clear),
      .load  (cnt_load),
      .step  (cnt_step),
      .cnt   (cnt),
      .done  (done)
   );

   assign q      = q_q;
   assign qbar   = ~q_q;
   assign sout_l = q_q[WIDTH-1];
   assign sout_r = q_q[0];

endmodule
